// File: rtl/timer_pkg.sv
// Shared register map, CTRL field positions, mode codes and FSM encoding
// for the memory-mapped down-counting timer.
package timer_pkg;

  // Word offsets decoded from PrAddr[3:2]
  localparam logic [1:0] ADDR_CTRL   = 2'b00;
  localparam logic [1:0] ADDR_PRESET = 2'b01;
  localparam logic [1:0] ADDR_COUNT  = 2'b10;
  localparam logic [1:0] ADDR_RSVD   = 2'b11;

  // CTRL bit positions
  localparam int CTRL_EN      = 0;
  localparam int CTRL_MODE_LO = 1;
  localparam int CTRL_MODE_HI = 2;
  localparam int CTRL_IM      = 3;
  localparam int CTRL_BITS    = 4;

  // MODE codes; 1x behaves as one-shot
  localparam logic [1:0] MODE_ONESHOT = 2'b00;
  localparam logic [1:0] MODE_RELOAD  = 2'b01;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_LOAD = 2'b01,
    S_CNT  = 2'b10,
    S_INT  = 2'b11
  } state_e;

endpackage

// File: rtl/timer_dev.sv
// Programmable down-counting timer: CTRL/PRESET/COUNT registers, a
// four-state counting FSM and a registered, maskable interrupt request.
module timer_dev
  import timer_pkg::*;
#(
  parameter int               WIDTH        = 32,
  parameter logic [WIDTH-1:0] RESET_PRESET = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       dev_addr,
  input  logic             dev_we,
  input  logic [WIDTH-1:0] dev_wdata,
  output logic [WIDTH-1:0] dev_rdata,
  output logic             irq
);

  logic [CTRL_BITS-1:0] ctrl_q, ctrl_d;
  logic [WIDTH-1:0]     preset_q, preset_d;
  logic [WIDTH-1:0]     count_q, count_d;
  state_e               state_q, state_d;
  logic                 irq_flag_q, irq_flag_d;
  logic                 irq_q, irq_d;

  logic wr_ctrl, wr_preset, en, reload;

  // Upper write-data bits only matter for PRESET; CTRL keeps the low nibble.
  logic unused_wdata;
  assign unused_wdata = ^dev_wdata;

  assign wr_ctrl   = dev_we && (dev_addr == ADDR_CTRL);
  assign wr_preset = dev_we && (dev_addr == ADDR_PRESET);
  assign en        = ctrl_q[CTRL_EN];
  assign reload    = (ctrl_q[CTRL_MODE_HI:CTRL_MODE_LO] == MODE_RELOAD);

  // Read mux: no side effects, reserved word reads as zero.
  always_comb begin
    dev_rdata = '0;
    case (dev_addr)
      ADDR_CTRL:   dev_rdata = {{(WIDTH-CTRL_BITS){1'b0}}, ctrl_q};
      ADDR_PRESET: dev_rdata = preset_q;
      ADDR_COUNT:  dev_rdata = count_q;
      default:     dev_rdata = '0;
    endcase
  end

  // Next-state: FSM first, then CPU writes so a CTRL write overrides the
  // FSM clearing EN at the end of a one-shot period.
  always_comb begin
    ctrl_d     = ctrl_q;
    preset_d   = preset_q;
    count_d    = count_q;
    state_d    = state_q;
    irq_flag_d = irq_flag_q;

    case (state_q)
      S_IDLE: begin
        if (en) state_d = S_LOAD;
      end
      S_LOAD: begin
        count_d = preset_q;
        state_d = S_CNT;
      end
      S_CNT: begin
        if (!en) begin
          state_d = S_IDLE;
        end else if (count_q > WIDTH'(1)) begin
          count_d = count_q - WIDTH'(1);
        end else begin
          count_d = '0;
          state_d = S_INT;
        end
      end
      S_INT: begin
        if (reload) begin
          state_d = S_LOAD;
        end else begin
          ctrl_d[CTRL_EN] = 1'b0;
          state_d         = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Auto-reload keeps the flag only for the INT cycle; one-shot holds it
    // until software touches CTRL or PRESET.
    if (state_q == S_INT) begin
      irq_flag_d = 1'b1;
    end else if (reload || wr_ctrl || wr_preset) begin
      irq_flag_d = 1'b0;
    end

    if (wr_ctrl)   ctrl_d   = dev_wdata[CTRL_BITS-1:0];
    if (wr_preset) preset_d = dev_wdata;

    irq_d = irq_flag_d & ctrl_d[CTRL_IM];
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_q     <= '0;
      preset_q   <= RESET_PRESET;
      count_q    <= '0;
      state_q    <= S_IDLE;
      irq_flag_q <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      ctrl_q     <= ctrl_d;
      preset_q   <= preset_d;
      count_q    <= count_d;
      state_q    <= state_d;
      irq_flag_q <= irq_flag_d;
      irq_q      <= irq_d;
    end
  end

  assign irq = irq_q;

endmodule

// File: tb/tb_timer_dev.sv
// Self-checking bench for timer_dev: register-map vector table followed by
// hand-written timing sequences (one-shot, auto-reload, mask, pause, reset).
module tb_timer_dev;

  localparam int WIDTH = 32;

  logic             clk;
  logic             rst;
  logic [1:0]       dev_addr;
  logic             dev_we;
  logic [WIDTH-1:0] dev_wdata;
  logic [WIDTH-1:0] dev_rdata;
  logic             irq;

  int tests_run;
  int tests_failed;

  timer_dev #(.WIDTH(WIDTH), .RESET_PRESET('0)) dut (
    .clk       (clk),
    .rst       (rst),
    .dev_addr  (dev_addr),
    .dev_we    (dev_we),
    .dev_wdata (dev_wdata),
    .dev_rdata (dev_rdata),
    .irq       (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_irq;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end else begin
      $display("[TB] ok %s = 0x%08h", name, act);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    dev_addr  = a;
    dev_wdata = d;
    dev_we    = 1'b1;
    tick();
    dev_we    = 1'b0;
  endtask

  task automatic rd_check(input string name, input logic [1:0] a, input logic [31:0] exp);
    dev_addr = a;
    #1;
    check(name, dev_rdata, exp);
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst       = 1'b1;
    dev_addr  = 2'b00;
    dev_we    = 1'b0;
    dev_wdata = '0;
    tick();
    tick();
    rst = 1'b0;

    // Register map vectors (EN kept 0 so the FSM stays idle)
    vecs[0] = '{1'b0, 2'b00, 32'h0,        32'h0,        1'b0};
    vecs[1] = '{1'b0, 2'b01, 32'h0,        32'h0,        1'b0};
    vecs[2] = '{1'b0, 2'b10, 32'h0,        32'h0,        1'b0};
    vecs[3] = '{1'b0, 2'b11, 32'h0,        32'h0,        1'b0};
    vecs[4] = '{1'b1, 2'b01, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0};
    vecs[5] = '{1'b1, 2'b10, 32'h00001234, 32'h0,        1'b0};
    vecs[6] = '{1'b1, 2'b11, 32'h0000FFFF, 32'h0,        1'b0};
    vecs[7] = '{1'b1, 2'b00, 32'hFFFFFFF6, 32'h00000006, 1'b0};
    vecs[8] = '{1'b0, 2'b01, 32'h0,        32'hDEADBEEF, 1'b0};
    vecs[9] = '{1'b1, 2'b00, 32'h0,        32'h0,        1'b0};

    for (int i = 0; i < 10; i++) begin
      if (vecs[i].we) wr(vecs[i].addr, vecs[i].wdata);
      rd_check($sformatf("vec%0d_rdata", i), vecs[i].addr, vecs[i].exp_rdata);
      check($sformatf("vec%0d_irq", i), {31'b0, irq}, {31'b0, vecs[i].exp_irq});
    end

    // One-shot: PRESET=5, CTRL=EN|IM; INT at e7, irq from e8 and held
    wr(2'b01, 32'd5);
    wr(2'b00, 32'h9);
    dev_addr = 2'b10;
    for (int k = 1; k <= 10; k++) begin
      logic [31:0] exp_cnt;
      tick();
      if (k == 1 || k >= 7) exp_cnt = 0;
      else                  exp_cnt = 32'(7 - k);
      check($sformatf("oneshot_count_e%0d", k), dev_rdata, exp_cnt);
      check($sformatf("oneshot_irq_e%0d", k), {31'b0, irq}, (k >= 8) ? 32'd1 : 32'd0);
    end
    rd_check("oneshot_ctrl_after", 2'b00, 32'h8);
    wr(2'b00, 32'h0);
    check("oneshot_irq_cleared", {31'b0, irq}, 32'd0);

    // Auto-reload: PRESET=3, CTRL=0xB; one-cycle pulse every 5 cycles
    wr(2'b01, 32'd3);
    wr(2'b00, 32'hB);
    for (int k = 1; k <= 21; k++) begin
      tick();
      check($sformatf("reload_irq_e%0d", k), {31'b0, irq},
            (k >= 6 && ((k - 6) % 5) == 0) ? 32'd1 : 32'd0);
    end

    // Reset while irq is high in auto-reload
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_irq", {31'b0, irq}, 32'd0);
    rd_check("rst_ctrl", 2'b00, 32'h0);
    rd_check("rst_preset", 2'b01, 32'h0);
    rd_check("rst_count", 2'b10, 32'h0);
    tick(); tick(); tick();
    rd_check("rst_idle_count", 2'b10, 32'h0);
    check("rst_idle_irq", {31'b0, irq}, 32'd0);

    // Masked: PRESET=3, CTRL=EN only; flag sets but irq stays low
    wr(2'b01, 32'd3);
    wr(2'b00, 32'h1);
    for (int k = 1; k <= 7; k++) begin
      tick();
      check($sformatf("masked_irq_e%0d", k), {31'b0, irq}, 32'd0);
    end
    rd_check("masked_ctrl_en_cleared", 2'b00, 32'h0);
    wr(2'b00, 32'h8);
    check("masked_unmask_irq", {31'b0, irq}, 32'd0);
    tick();
    check("masked_unmask_irq_next", {31'b0, irq}, 32'd0);

    // Pause/resume: PRESET=10; disable at COUNT=6, then re-enable reloads
    wr(2'b00, 32'h0);
    wr(2'b01, 32'd10);
    wr(2'b00, 32'h1);
    dev_addr = 2'b10;
    for (int k = 1; k <= 5; k++) tick();
    rd_check("pause_count_e5", 2'b10, 32'd7);
    wr(2'b00, 32'h0);
    rd_check("pause_count_e6", 2'b10, 32'd6);
    for (int k = 0; k < 3; k++) begin
      tick();
      rd_check($sformatf("pause_hold_%0d", k), 2'b10, 32'd6);
    end
    wr(2'b00, 32'h1);
    rd_check("resume_f0", 2'b10, 32'd6);
    tick();
    rd_check("resume_f1", 2'b10, 32'd6);
    tick();
    rd_check("resume_reload_f2", 2'b10, 32'd10);
    tick();
    rd_check("resume_f3", 2'b10, 32'd9);
    wr(2'b01, 32'd4);
    rd_check("midpreset_f4", 2'b10, 32'd8);
    tick();
    rd_check("midpreset_f5", 2'b10, 32'd7);
    wr(2'b00, 32'h0);
    tick();
    rd_check("midpreset_paused", 2'b10, 32'd6);
    wr(2'b00, 32'h1);
    tick();
    tick();
    rd_check("newpreset_loaded", 2'b10, 32'd4);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // Watchdog so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
